// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus shared between execute stage, LSU and word memory.
// The LSU sits on the slave side; the execute stage and memory together form the master side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        load_valid;
    logic        store_done;
    logic        fault;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] write_data;
    logic [31:0] Read_data;

    modport slave (
        input  req_valid, is_load, is_store, funct3, addr, store_data, Read_data,
        output req_ready, load_data, load_valid, store_done, fault,
               MemRead, MemWrite, Address, write_data
    );

    modport master (
        output req_valid, is_load, is_store, funct3, addr, store_data, Read_data,
        input  req_ready, load_data, load_valid, store_done, fault,
               MemRead, MemWrite, Address, write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a word-wide memory with combinational reads.
// Sub-word stores are done as read (in IDLE) then write (in RMW_WRITE) of a merged word.
module load_store_unit #(
    parameter int unsigned WORD_ADDR_BITS = 6
) (
    input logic             clk_i,
    input logic             reset_i,
    load_store_unit_if.slave bus
);
    localparam int unsigned HiBit = WORD_ADDR_BITS + 1;

    typedef enum logic [0:0] {StIdle, StRmwWrite} state_e;

    state_e                    state_q;
    logic [31:0]               load_data_q;
    logic [31:0]               merged_q;
    logic [WORD_ADDR_BITS-1:0] word_idx_q;
    logic                      load_valid_q;
    logic                      store_done_q;
    logic                      fault_q;

    logic                      accept;
    logic                      is_byte;
    logic                      is_half;
    logic                      is_word;
    logic                      op_bad;
    logic                      f3_bad;
    logic                      misaligned;
    logic                      out_of_range;
    logic                      req_fault;
    logic [WORD_ADDR_BITS-1:0] word_idx;
    logic [7:0]                sel_byte;
    logic [15:0]               sel_half;
    logic [31:0]               load_ext;
    logic [31:0]               merged;

    assign word_idx = bus.addr[HiBit:2];
    assign is_byte  = (bus.funct3[1:0] == 2'b00);
    assign is_half  = (bus.funct3[1:0] == 2'b01);
    assign is_word  = (bus.funct3[1:0] == 2'b10);

    assign op_bad       = (bus.is_load == bus.is_store);
    assign misaligned   = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
    assign out_of_range = |bus.addr[31:HiBit+1];
    assign req_fault    = op_bad || f3_bad || misaligned || out_of_range;

    // Reset wins over everything so an aborted RMW never reaches memory.
    assign accept = bus.req_valid && (state_q == StIdle) && !reset_i;

    always_comb begin
        f3_bad = 1'b0;
        if (bus.is_load) begin
            f3_bad = !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else begin
            f3_bad = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
        end
    end

    assign sel_byte = bus.Read_data[{bus.addr[1:0], 3'b000} +: 8];
    assign sel_half = bus.addr[1] ? bus.Read_data[31:16] : bus.Read_data[15:0];

    always_comb begin
        load_ext = bus.Read_data;
        case (bus.funct3)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_ext = {24'h0, sel_byte};
            3'b101:  load_ext = {16'h0, sel_half};
            default: load_ext = bus.Read_data;
        endcase
    end

    always_comb begin
        merged = bus.Read_data;
        if (is_byte) begin
            merged[{bus.addr[1:0], 3'b000} +: 8] = bus.store_data[7:0];
        end else if (is_half) begin
            merged[{bus.addr[1], 4'b0000} +: 16] = bus.store_data[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            load_data_q  <= 32'h0;
            merged_q     <= 32'h0;
            word_idx_q   <= '0;
            load_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            fault_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (req_fault) begin
                            fault_q <= 1'b1;
                        end else if (bus.is_load) begin
                            load_valid_q <= 1'b1;
                            load_data_q  <= load_ext;
                        end else if (!is_word) begin
                            merged_q   <= merged;
                            word_idx_q <= word_idx;
                            state_q    <= StRmwWrite;
                        end else begin
                            store_done_q <= 1'b1;
                        end
                    end
                end
                StRmwWrite: begin
                    state_q      <= StIdle;
                    store_done_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.Address    = 32'h0;
        bus.write_data = 32'h0;
        if (!reset_i) begin
            if (state_q == StRmwWrite) begin
                bus.MemWrite   = 1'b1;
                bus.Address    = 32'(word_idx_q);
                bus.write_data = merged_q;
            end else if (accept && !req_fault) begin
                bus.Address = 32'(word_idx);
                if (bus.is_store && is_word) begin
                    bus.MemWrite   = 1'b1;
                    bus.write_data = bus.store_data;
                end else begin
                    bus.MemRead = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.load_data  = load_data_q;
    assign bus.load_valid = load_valid_q;
    assign bus.store_done = store_done_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random requests checked against a
// byte-array memory model; a word-wide memory behind the bus serves the DUT.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.WORD_ADDR_BITS(6)) u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    logic [31:0] mem [64] = '{default: 32'h0};
    assign bus.Read_data = bus.MemRead ? mem[bus.Address[5:0]] : 32'h0;
    always @(posedge clk) if (bus.MemWrite) mem[bus.Address[5:0]] <= bus.write_data;

    int          n_checks = 0;
    int          n_fails = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  ref_mem [256] = '{default: 8'h0};
    logic [31:0] last_load = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("excl_mem", 32'(bus.MemRead && bus.MemWrite), 32'h0);
            check("excl_pulse", 32'($countones({bus.load_valid, bus.store_done, bus.fault}) > 1),
                  32'h0);
        end
    end

    function automatic bit model_fault(bit ld, bit st, logic [2:0] f3, logic [31:0] a);
        int n;
        if (ld == st) return 1'b1;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (st && f3 > 3'd2) return 1'b1;
        n = 1 << f3[1:0];
        if (a % n != 0) return 1'b1;
        if (a >= 256) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a);
        int          n = 1 << f3[1:0];
        int          sh;
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
        if (!f3[2] && n < 4) begin
            sh = 32 - 8 * n;
            v = 32'($signed(v << sh) >>> sh);
        end
        return v;
    endfunction

    function automatic logic [31:0] word_at(int base);
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    endfunction

    // One request from IDLE, followed through to completion. Starts and ends 1ns after posedge.
    task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        bit          flt;
        int          n;
        logic [31:0] exp_ld = 32'h0;
        logic [31:0] exp_wd = 32'h0;
        flt = model_fault(ld, st, f3, a);
        n   = 1 << f3[1:0];
        bus.req_valid  = 1'b1;
        bus.is_load    = ld;
        bus.is_store   = st;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = d;
        #4;
        check("req_ready", 32'(bus.req_ready), 32'h1);
        if (flt) begin
            check("fault_memrd", 32'(bus.MemRead), 32'h0);
            check("fault_memwr", 32'(bus.MemWrite), 32'h0);
        end else if (ld) begin
            check("ld_memrd", 32'(bus.MemRead), 32'h1);
            check("ld_addr", bus.Address, a >> 2);
            exp_ld = model_load(f3, a);
        end else if (n == 4) begin
            check("sw_memwr", 32'(bus.MemWrite), 32'h1);
            check("sw_addr", bus.Address, a >> 2);
            check("sw_wdata", bus.write_data, d);
            for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = d[8 * k +: 8];
        end else begin
            check("rmw_memrd", 32'(bus.MemRead), 32'h1);
            check("rmw_rd_addr", bus.Address, a >> 2);
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = d[8 * k +: 8];
            exp_wd = word_at(int'(a) & ~3);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("fault", 32'(bus.fault), 32'(flt));
        check("load_valid", 32'(bus.load_valid), 32'(!flt && ld));
        check("store_done", 32'(bus.store_done), 32'(!flt && st && n == 4));
        if (!flt && ld) last_load = exp_ld;
        check("load_data", bus.load_data, last_load);
        if (!flt && st && n < 4) begin
            #4;
            check("rmw_ready", 32'(bus.req_ready), 32'h0);
            check("rmw_memwr", 32'(bus.MemWrite), 32'h1);
            check("rmw_memrd_off", 32'(bus.MemRead), 32'h0);
            check("rmw_addr", bus.Address, a >> 2);
            check("rmw_wdata", bus.write_data, exp_wd);
            @(posedge clk); #1;
            check("rmw_done", 32'(bus.store_done), 32'h1);
            check("rmw_ready_back", 32'(bus.req_ready), 32'h1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
        check({tag, "_ldata"}, bus.load_data, 32'h0);
        check({tag, "_lvalid"}, 32'(bus.load_valid), 32'h0);
        check({tag, "_sdone"}, 32'(bus.store_done), 32'h0);
        check({tag, "_fault"}, 32'(bus.fault), 32'h0);
        check({tag, "_memrd"}, 32'(bus.MemRead), 32'h0);
        check({tag, "_memwr"}, 32'(bus.MemWrite), 32'h0);
        check({tag, "_addr"}, bus.Address, 32'h0);
        check({tag, "_wdata"}, bus.write_data, 32'h0);
    endtask

    initial begin
        int          r;
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] exp_wd;

        bus.req_valid  = 1'b0;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b0;
        bus.funct3     = 3'b000;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;

        @(posedge clk); #1;
        check_reset_state("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Word store then word load
        do_req(0, 1, 3'b010, 32'h08, 32'hDEADBEEF);
        do_req(1, 0, 3'b010, 32'h08, 32'h0);
        check("t1_lw", bus.load_data, 32'hDEADBEEF);

        // Sub-word loads
        do_req(1, 0, 3'b000, 32'h0B, 32'h0);
        check("t2_lb", bus.load_data, 32'hFFFFFFDE);
        do_req(1, 0, 3'b100, 32'h0B, 32'h0);
        check("t2_lbu", bus.load_data, 32'h000000DE);
        do_req(1, 0, 3'b001, 32'h0A, 32'h0);
        check("t2_lh", bus.load_data, 32'hFFFFDEAD);
        do_req(1, 0, 3'b101, 32'h08, 32'h0);
        check("t2_lhu", bus.load_data, 32'h0000BEEF);

        // Byte store via read-modify-write
        do_req(0, 1, 3'b000, 32'h09, 32'h00000012);
        do_req(1, 0, 3'b010, 32'h08, 32'h0);
        check("t3_lw", bus.load_data, 32'hDEAD12EF);

        // Faulting requests leave memory alone
        do_req(1, 0, 3'b010, 32'h06, 32'h0);
        do_req(0, 1, 3'b001, 32'h05, 32'hFFFFFFFF);
        do_req(1, 0, 3'b000, 32'h100, 32'h0);
        do_req(1, 0, 3'b011, 32'h08, 32'h0);
        do_req(1, 1, 3'b010, 32'h08, 32'h0);
        do_req(0, 0, 3'b010, 32'h08, 32'h0);
        do_req(1, 0, 3'b010, 32'h08, 32'h0);
        check("t4_lw", bus.load_data, 32'hDEAD12EF);

        // Reset during RMW_WRITE aborts the write
        do_req(0, 1, 3'b010, 32'h0C, 32'h01234567);
        bus.req_valid  = 1'b1;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b1;
        bus.funct3     = 3'b001;
        bus.addr       = 32'h0C;
        bus.store_data = 32'hAAAA5555;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #4;
        check("t5_no_write", 32'(bus.MemWrite), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_load = 32'h0;
        check_reset_state("t5");
        do_req(1, 0, 3'b010, 32'h0C, 32'h0);
        check("t5_mem_kept", bus.load_data, 32'h01234567);

        // Back-to-back loads
        do_req(0, 1, 3'b010, 32'h00, 32'h11223344);
        do_req(0, 1, 3'b010, 32'h04, 32'h55667788);
        bus.req_valid = 1'b1;
        bus.is_load   = 1'b1;
        bus.is_store  = 1'b0;
        bus.funct3    = 3'b010;
        bus.addr      = 32'h00;
        #4;
        check("t6_addr0", bus.Address, 32'h0);
        @(posedge clk); #1;
        bus.addr = 32'h04;
        check("t6_lv0", 32'(bus.load_valid), 32'h1);
        check("t6_ld0", bus.load_data, 32'h11223344);
        #4;
        check("t6_addr1", bus.Address, 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("t6_lv1", 32'(bus.load_valid), 32'h1);
        check("t6_ld1", bus.load_data, 32'h55667788);

        // A load held across RMW_WRITE is taken exactly once
        bus.req_valid  = 1'b1;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b1;
        bus.funct3     = 3'b000;
        bus.addr       = 32'h05;
        bus.store_data = 32'h00000099;
        ref_mem[5]     = 8'h99;
        exp_wd         = word_at(4);
        @(posedge clk); #1;
        bus.is_load  = 1'b1;
        bus.is_store = 1'b0;
        bus.funct3   = 3'b010;
        bus.addr     = 32'h04;
        #4;
        check("t6_hold_ready", 32'(bus.req_ready), 32'h0);
        check("t6_hold_wr", 32'(bus.MemWrite), 32'h1);
        check("t6_hold_wdata", bus.write_data, exp_wd);
        @(posedge clk); #1;
        check("t6_hold_done", 32'(bus.store_done), 32'h1);
        check("t6_hold_not_yet", 32'(bus.load_valid), 32'h0);
        #4;
        check("t6_hold_rd", 32'(bus.MemRead), 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("t6_hold_lv", 32'(bus.load_valid), 32'h1);
        check("t6_hold_ld", bus.load_data, 32'h55669988);
        last_load = 32'h55669988;
        @(posedge clk); #1;
        check("t6_once", 32'(bus.load_valid), 32'h0);

        // Random requests
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                ld = 1'b1; st = 1'b1;
            end else if (r == 1) begin
                ld = 1'b0; st = 1'b0;
            end else begin
                ld = r[0]; st = !r[0];
            end
            f3 = 3'($urandom_range(0, 7));
            if (st && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) a = a & 32'hFC;
            if ($urandom_range(0, 19) == 0) a = $urandom();
            do_req(ld, st, f3, a, $urandom());
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
